// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode constants, operand selectors and the micro-op record.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_RS,
        SEL_PC,
        SEL_IMM
    } opsel_t;

    typedef struct packed {
        logic [6:0] aluop;
        logic [2:0] alusel;
        logic [6:0] aluc;
        logic [4:0] wd;
        logic       wreg;
        logic       wmem;
        logic       rmem;
        logic       branch;
        logic       jump;
        logic       illegal;
    } uop_t;

    function automatic logic is_shift_imm(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/rv_fwd_mux.sv
// Per-operand forwarding select: the youngest matching source wins, x0 always reads as zero.
module rv_fwd_mux
    import rv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int FWD_PORTS = 2
) (
    input  logic [4:0]              addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [FWD_PORTS-1:0]    fwd_wreg,
    input  logic [5*FWD_PORTS-1:0]  fwd_wd,
    input  logic [XLEN*FWD_PORTS-1:0] fwd_wdata,
    input  logic [FWD_PORTS-1:0]    fwd_rmem,
    output logic [XLEN-1:0]         data,
    output logic                    load_pending
);

    // Walk from oldest to youngest so the lowest matching index overrides the rest.
    always_comb begin
        data         = rf_data;
        load_pending = 1'b0;
        for (int k = FWD_PORTS - 1; k >= 0; k--) begin
            if (fwd_wreg[k] && (fwd_wd[5*k +: 5] == addr)) begin
                data         = fwd_wdata[XLEN*k +: XLEN];
                load_pending = fwd_rmem[k];
            end
        end
        if (addr == 5'd0) begin
            data         = '0;
            load_pending = 1'b0;
        end
    end

endmodule

// File: rtl/rv_id_stage.sv
// RV32I decode stage with valid/ready output register, operand forwarding and load-use stall.
// Define RV_ID_ILLEGAL_TRAP_EN to pass illegal instructions downstream flagged with illegal_o.
module rv_id_stage
    import rv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int FWD_PORTS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [31:0]               inst_i,
    output logic [4:0]                rs1_addr_o,
    output logic [4:0]                rs2_addr_o,
    input  logic [XLEN-1:0]           rs1_data_i,
    input  logic [XLEN-1:0]           rs2_data_i,
    input  logic [FWD_PORTS-1:0]      fwd_wreg_i,
    input  logic [5*FWD_PORTS-1:0]    fwd_wd_i,
    input  logic [XLEN*FWD_PORTS-1:0] fwd_wdata_i,
    input  logic [FWD_PORTS-1:0]      fwd_rmem_i,
    input  logic                      flush_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           pc_o,
    output logic [6:0]                aluop_o,
    output logic [2:0]                alusel_o,
    output logic [6:0]                aluc_o,
    output logic [XLEN-1:0]           reg1_o,
    output logic [XLEN-1:0]           reg2_o,
    output logic [XLEN-1:0]           imm_o,
    output logic [4:0]                wd_o,
    output logic                      wreg_o,
    output logic                      wmem_o,
    output logic                      rmem_o,
    output logic                      branch_o,
    output logic                      jump_o,
    output logic                      illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode     = inst_i[6:0];
    assign rd         = inst_i[11:7];
    assign funct3     = inst_i[14:12];
    assign funct7     = inst_i[31:25];
    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_pending;
    logic            rs2_pending;

    rv_fwd_mux #(.XLEN(XLEN), .FWD_PORTS(FWD_PORTS)) u_fwd_rs1 (
        .addr         (rs1_addr_o),
        .rf_data      (rs1_data_i),
        .fwd_wreg     (fwd_wreg_i),
        .fwd_wd       (fwd_wd_i),
        .fwd_wdata    (fwd_wdata_i),
        .fwd_rmem     (fwd_rmem_i),
        .data         (rs1_val),
        .load_pending (rs1_pending)
    );

    rv_fwd_mux #(.XLEN(XLEN), .FWD_PORTS(FWD_PORTS)) u_fwd_rs2 (
        .addr         (rs2_addr_o),
        .rf_data      (rs2_data_i),
        .fwd_wreg     (fwd_wreg_i),
        .fwd_wd       (fwd_wd_i),
        .fwd_wdata    (fwd_wdata_i),
        .fwd_rmem     (fwd_rmem_i),
        .data         (rs2_val),
        .load_pending (rs2_pending)
    );

    logic               legal;
    logic               use_rs1;
    logic               use_rs2;
    logic               writes_rd;
    logic signed [31:0] imm32;
    opsel_t             sel1;
    opsel_t             sel2;
    uop_t               uop_d;

    always_comb begin
        legal     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        imm32     = '0;
        sel1      = SEL_ZERO;
        sel2      = SEL_ZERO;
        uop_d        = '0;
        uop_d.aluop  = opcode;
        uop_d.alusel = funct3;
        uop_d.wd     = rd;
        case (opcode)
            OP: begin
                sel1 = SEL_RS; sel2 = SEL_RS;
                use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
                uop_d.aluc = funct7;
            end
            OP_IMM: begin
                sel1 = SEL_RS; sel2 = SEL_IMM;
                use_rs1 = 1'b1; writes_rd = 1'b1;
                if (is_shift_imm(funct3)) begin
                    imm32      = {27'b0, inst_i[24:20]};
                    uop_d.aluc = funct7;
                end else begin
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end
            end
            LOAD: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                sel1 = SEL_RS; sel2 = SEL_IMM;
                use_rs1 = 1'b1; writes_rd = 1'b1;
                uop_d.rmem = 1'b1;
            end
            STORE: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
                imm32 = {{20{inst_i[31]}}, funct7, rd};
                sel1 = SEL_RS; sel2 = SEL_RS;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                uop_d.wmem = 1'b1;
            end
            BRANCH: begin
                legal = !(funct3 inside {3'b010, 3'b011});
                imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
                sel1 = SEL_RS; sel2 = SEL_RS;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                uop_d.branch = 1'b1;
            end
            LUI: begin
                imm32 = {inst_i[31:12], 12'b0};
                sel1 = SEL_ZERO; sel2 = SEL_IMM;
                writes_rd = 1'b1;
            end
            AUIPC: begin
                imm32 = {inst_i[31:12], 12'b0};
                sel1 = SEL_PC; sel2 = SEL_IMM;
                writes_rd = 1'b1;
            end
            JAL: begin
                imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
                sel1 = SEL_PC; sel2 = SEL_IMM;
                writes_rd = 1'b1;
                uop_d.jump = 1'b1;
            end
            JALR: begin
                legal = (funct3 == 3'b000);
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                sel1 = SEL_RS; sel2 = SEL_IMM;
                use_rs1 = 1'b1; writes_rd = 1'b1;
                uop_d.jump = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        uop_d.wreg = writes_rd && (rd != 5'd0);
        // An undecodable word must never stall or write anything downstream.
        if (!legal) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
`ifdef RV_ID_ILLEGAL_TRAP_EN
            uop_d.wreg    = 1'b0;
            uop_d.wmem    = 1'b0;
            uop_d.rmem    = 1'b0;
            uop_d.branch  = 1'b0;
            uop_d.jump    = 1'b0;
            uop_d.illegal = 1'b1;
`else
            uop_d       = '0;
            uop_d.aluop = OP_IMM;
            sel1        = SEL_ZERO;
            sel2        = SEL_ZERO;
            imm32       = '0;
`endif
        end
    end

    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] reg1_d;
    logic [XLEN-1:0] reg2_d;

    always_comb begin
        imm_d = XLEN'(imm32);
        case (sel1)
            SEL_RS:  reg1_d = rs1_val;
            SEL_PC:  reg1_d = pc_i;
            SEL_IMM: reg1_d = imm_d;
            default: reg1_d = '0;
        endcase
        case (sel2)
            SEL_RS:  reg2_d = rs2_val;
            SEL_PC:  reg2_d = pc_i;
            SEL_IMM: reg2_d = imm_d;
            default: reg2_d = '0;
        endcase
    end

    logic stall;
    logic load_en;

    assign stall    = in_valid & ((use_rs1 & rs1_pending) | (use_rs2 & rs2_pending));
    assign load_en  = ~out_valid | out_ready;
    assign in_ready = (~stall & load_en) | flush_i;

    uop_t            uop_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] reg1_q;
    logic [XLEN-1:0] reg2_q;
    logic [XLEN-1:0] imm_q;

    // Reset and flush both empty the register; otherwise it refills with a micro-op or a bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            out_valid <= 1'b0;
            uop_q     <= '0;
            pc_q      <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            imm_q     <= '0;
        end else if (load_en) begin
            if (in_valid && !stall) begin
                out_valid <= 1'b1;
                uop_q     <= uop_d;
                pc_q      <= pc_i;
                reg1_q    <= reg1_d;
                reg2_q    <= reg2_d;
                imm_q     <= imm_d;
            end else begin
                out_valid <= 1'b0;
                uop_q     <= '0;
                pc_q      <= '0;
                reg1_q    <= '0;
                reg2_q    <= '0;
                imm_q     <= '0;
            end
        end
    end

    assign pc_o      = pc_q;
    assign aluop_o   = uop_q.aluop;
    assign alusel_o  = uop_q.alusel;
    assign aluc_o    = uop_q.aluc;
    assign reg1_o    = reg1_q;
    assign reg2_o    = reg2_q;
    assign imm_o     = imm_q;
    assign wd_o      = uop_q.wd;
    assign wreg_o    = uop_q.wreg;
    assign wmem_o    = uop_q.wmem;
    assign rmem_o    = uop_q.rmem;
    assign branch_o  = uop_q.branch;
    assign jump_o    = uop_q.jump;
    assign illegal_o = uop_q.illegal;

endmodule
